// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC capture controller: record layout,
// serializer states and the output stream packing.
package lpc_pkg;

  localparam int REC_W     = 44;
  localparam int REC_BYTES = 6;
  localparam int LOST_BIT  = 7;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic [31:0] addr;
    logic [7:0]  data;
  } lpc_rec_t;

  // Byte 0 carries the lost flag and cycle type; address MSB first, then data.
  function automatic logic [REC_BYTES*8-1:0] pack_stream(input logic lost, input lpc_rec_t rec);
    logic [7:0] b0;
    b0           = '0;
    b0[LOST_BIT] = lost;
    b0[3:0]      = rec.cyctype_dir;
    return {b0, rec.addr, rec.data};
  endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// Synchronous record FIFO with exact occupancy count; DEPTH must be a power of
// two so the pointers wrap on their own.
module lpc_record_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage carries no reset; the level counter alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lpc_capture_ctrl.sv
// Captures completed LPC decoder cycles, optionally filtered by address, queues
// them and serializes each record as a 6-byte valid/ready stream.
module lpc_capture_ctrl
  import lpc_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] FILTER_ADDR = 32'h0000_0080,
  parameter logic [31:0] FILTER_MASK = 32'hFFFF_FFFF
) (
  input  logic                          lpc_clock,
  input  logic                          reset,
  input  logic [3:0]                    in_cyctype_dir,
  input  logic [31:0]                   in_addr,
  input  logic [7:0]                    in_data,
  input  logic                          in_clock_enable,
  input  logic                          filter_en,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int         SR_W     = REC_BYTES * 8;
  localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

  logic       ce_q;
  logic       lost;
  logic       cap_event;
  logic       addr_match;
  logic       accept;
  logic       push;
  logic       drop;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  lpc_rec_t   wr_rec;
  lpc_rec_t   rd_rec;

  ser_state_t      state;
  logic [2:0]      idx;
  logic [SR_W-1:0] shreg;

  assign cap_event  = in_clock_enable & ~ce_q;
  assign addr_match = (((in_addr ^ FILTER_ADDR) & FILTER_MASK) == '0);
  assign accept     = cap_event & (~filter_en | addr_match);
  // Full is the start-of-cycle occupancy, so a same-cycle pop never rescues a record.
  assign push       = accept & ~fifo_full;
  assign drop       = accept & fifo_full;
  assign pop        = (state == S_IDLE) & ~fifo_empty;
  assign wr_rec     = '{cyctype_dir: in_cyctype_dir, addr: in_addr, data: in_data};

  lpc_record_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (lpc_clock),
    .reset (reset),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (rd_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ce_q resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      ce_q       <= 1'b1;
      drop_count <= '0;
      lost       <= 1'b0;
    end else begin
      ce_q <= in_clock_enable;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      // A drop wins over the clear so it is reported in the following record.
      if (drop)     lost <= 1'b1;
      else if (pop) lost <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shreg     <= pack_stream(lost, rd_rec);
            out_byte  <= pack_stream(lost, rd_rec)[SR_W-1 -: 8];
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_byte  <= '0;
              idx       <= '0;
              state     <= S_IDLE;
            end else begin
              idx      <= idx + 3'd1;
              shreg    <= {shreg[SR_W-9:0], 8'h00};
              out_byte <= shreg[SR_W-9 -: 8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
